// File: rtl/axil_ram_pkg.sv
// Shared response codes, geometry helpers and parameter sanity check for the line RAM.
package axil_ram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Words per line.
    function automatic int unsigned calc_lw(input int unsigned data_w,
                                            input int unsigned word_w);
        return data_w / word_w;
    endfunction

    // Byte strobes per line.
    function automatic int unsigned calc_sw(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // A line must be whole words of whole bytes, the array must fit the address space,
    // and a line must not be longer than the array (the wrap logic subtracts DEPTH once).
    function automatic bit cfg_ok(input int unsigned data_w, input int unsigned word_w,
                                  input int unsigned addr_w, input int unsigned depth);
        return (word_w != 0) && (data_w % word_w == 0) && (word_w % 8 == 0) &&
               (depth >= 2) && (64'(depth) <= (64'd1 << addr_w)) &&
               (data_w / word_w <= depth);
    endfunction

endpackage

// File: rtl/axil_ram_bank.sv
// Single-port line array: LW consecutive words per access, wrapping modulo DEPTH,
// byte-enable write and a registered read port that can return an all-zero line.
module axil_ram_bank
    import axil_ram_pkg::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned WORD_W = 64,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we_i,
    input  logic                       re_i,
    input  logic                       zero_i,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [calc_sw(DATA_W)-1:0] wstrb_i,
    output logic [DATA_W-1:0]          rdata_o
);

    localparam int unsigned LW    = calc_lw(DATA_W, WORD_W);
    localparam int unsigned BPW   = WORD_W / 8;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx [LW];
    logic [DATA_W-1:0] rd_line;
    logic [DATA_W-1:0] rdata_d, rdata_q;

    // Word index for each slot of the line; addr_i < DEPTH whenever it matters,
    // so one conditional subtract is enough to wrap.
    always_comb begin
        logic [ADDR_W:0] sum;
        sum = '0;
        for (int k = 0; k < LW; k++) begin
            sum = {1'b0, addr_i} + (ADDR_W+1)'(k);
            if (sum >= (ADDR_W+1)'(DEPTH)) begin
                sum = sum - (ADDR_W+1)'(DEPTH);
            end
            idx[k] = IDX_W'(sum);
        end
    end

    // Gather the addressed line and pick the next read register value.
    always_comb begin
        rd_line = '0;
        for (int k = 0; k < LW; k++) begin
            rd_line[k*WORD_W +: WORD_W] = mem[idx[k]];
        end
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = zero_i ? '0 : rd_line;
        end
    end

    // Byte-masked write of the line; storage has no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < LW; k++) begin
                for (int b = 0; b < BPW; b++) begin
                    if (wstrb_i[k*BPW + b]) begin
                        mem[idx[k]][b*8 +: 8] <= wdata_i[k*WORD_W + b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read data register, held between reads so the R channel stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_line_ram.sv
// AXI4-Lite line memory: one-entry AW/W/AR holding registers, B and R response
// registers, and an alternating-priority arbiter in front of a single-port bank.
module axil_line_ram
    import axil_ram_pkg::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned WORD_W = 64,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          ram_axi_awaddr,
    input  logic                       ram_axi_awvalid,
    output logic                       ram_axi_awready,
    input  logic [DATA_W-1:0]          ram_axi_wdata,
    input  logic [calc_sw(DATA_W)-1:0] ram_axi_wstrb,
    input  logic                       ram_axi_wvalid,
    output logic                       ram_axi_wready,
    output logic [1:0]                 ram_axi_bresp,
    output logic                       ram_axi_bvalid,
    input  logic                       ram_axi_bready,
    input  logic [ADDR_W-1:0]          ram_axi_araddr,
    input  logic                       ram_axi_arvalid,
    output logic                       ram_axi_arready,
    output logic [DATA_W-1:0]          ram_axi_rdata,
    output logic [1:0]                 ram_axi_rresp,
    output logic                       ram_axi_rvalid,
    input  logic                       ram_axi_rready
);

    localparam int unsigned SW = calc_sw(DATA_W);

    if (!cfg_ok(DATA_W, WORD_W, ADDR_W, DEPTH)) begin : g_cfg_err
        $error("axil_line_ram: invalid DATA_W/WORD_W/ADDR_W/DEPTH combination");
    end

    logic              aw_held_d, aw_held_q;
    logic [ADDR_W-1:0] aw_addr_d, aw_addr_q;
    logic              w_held_d, w_held_q;
    logic [DATA_W-1:0] w_data_d, w_data_q;
    logic [SW-1:0]     w_strb_d, w_strb_q;
    logic              ar_held_d, ar_held_q;
    logic [ADDR_W-1:0] ar_addr_d, ar_addr_q;
    logic              bvalid_d, bvalid_q;
    logic [1:0]        bresp_d, bresp_q;
    logic              rvalid_d, rvalid_q;
    logic [1:0]        rresp_d, rresp_q;
    logic              last_rd_d, last_rd_q;

    logic wr_cand, rd_cand, wr_go, rd_go, wr_oor, rd_oor;

    // Readies depend only on holding flops (and reset), never on a valid.
    assign ram_axi_awready = ~aw_held_q & ~rst;
    assign ram_axi_wready  = ~w_held_q & ~rst;
    assign ram_axi_arready = ~ar_held_q & ~rst;

    // Arbitration: on a tie the type that did not commit last goes first.
    always_comb begin
        wr_cand = aw_held_q & w_held_q & (~bvalid_q | ram_axi_bready);
        rd_cand = ar_held_q & (~rvalid_q | ram_axi_rready);
        wr_go   = ~rst & wr_cand & (~rd_cand | last_rd_q);
        rd_go   = ~rst & rd_cand & ~wr_go;
        wr_oor  = {1'b0, aw_addr_q} >= (ADDR_W+1)'(DEPTH);
        rd_oor  = {1'b0, ar_addr_q} >= (ADDR_W+1)'(DEPTH);
    end

    // Next state of holding registers, response registers and the fairness flag.
    always_comb begin
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        ar_held_d = ar_held_q;
        ar_addr_d = ar_addr_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        last_rd_d = last_rd_q;

        if (wr_go) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            last_rd_d = 1'b0;
        end
        if (rd_go) begin
            ar_held_d = 1'b0;
            last_rd_d = 1'b1;
        end
        if (ram_axi_awvalid && ram_axi_awready) begin
            aw_held_d = 1'b1;
            aw_addr_d = ram_axi_awaddr;
        end
        if (ram_axi_wvalid && ram_axi_wready) begin
            w_held_d = 1'b1;
            w_data_d = ram_axi_wdata;
            w_strb_d = ram_axi_wstrb;
        end
        if (ram_axi_arvalid && ram_axi_arready) begin
            ar_held_d = 1'b1;
            ar_addr_d = ram_axi_araddr;
        end

        // A response retiring and a new one loading may share an edge.
        if (bvalid_q && ram_axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (wr_go) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_oor ? RESP_SLVERR : RESP_OKAY;
        end
        if (rvalid_q && ram_axi_rready) begin
            rvalid_d = 1'b0;
        end
        if (rd_go) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_oor ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // State registers; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            ar_held_q <= 1'b0;
            ar_addr_q <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            last_rd_q <= 1'b1;
        end else begin
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            ar_held_q <= ar_held_d;
            ar_addr_q <= ar_addr_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            last_rd_q <= last_rd_d;
        end
    end

    axil_ram_bank #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_go & ~wr_oor),
        .re_i    (rd_go),
        .zero_i  (rd_oor),
        .addr_i  (wr_go ? aw_addr_q : ar_addr_q),
        .wdata_i (w_data_q),
        .wstrb_i (w_strb_q),
        .rdata_o (ram_axi_rdata)
    );

    assign ram_axi_bvalid = bvalid_q;
    assign ram_axi_bresp  = bresp_q;
    assign ram_axi_rvalid = rvalid_q;
    assign ram_axi_rresp  = rresp_q;

endmodule

// File: tb/tb_axil_line_ram.sv
// Bench for axil_line_ram: directed table, random traffic against a word-array model,
// and hand-written sequences for latency, arbitration, back-pressure and reset.
module tb_axil_line_ram;

    localparam int DATA_W = 256;
    localparam int WORD_W = 64;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1024;
    localparam int LW     = DATA_W / WORD_W;
    localparam int SW     = DATA_W / 8;

    typedef logic [DATA_W-1:0] line_t;

    typedef struct {
        bit          rd;
        logic [11:0] addr;
        line_t       data;
        logic [31:0] strb;
        logic [1:0]  eresp;
        line_t       edata;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    line_t             wdata, rdata;
    logic [SW-1:0]     wstrb;
    logic [1:0]        bresp, rresp;

    int checks = 0;
    int errors = 0;
    logic [WORD_W-1:0] mdl [DEPTH];

    always #5 clk = ~clk;

    axil_line_ram #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ram_axi_awaddr  (awaddr),
        .ram_axi_awvalid (awvalid),
        .ram_axi_awready (awready),
        .ram_axi_wdata   (wdata),
        .ram_axi_wstrb   (wstrb),
        .ram_axi_wvalid  (wvalid),
        .ram_axi_wready  (wready),
        .ram_axi_bresp   (bresp),
        .ram_axi_bvalid  (bvalid),
        .ram_axi_bready  (bready),
        .ram_axi_araddr  (araddr),
        .ram_axi_arvalid (arvalid),
        .ram_axi_arready (arready),
        .ram_axi_rdata   (rdata),
        .ram_axi_rresp   (rresp),
        .ram_axi_rvalid  (rvalid),
        .ram_axi_rready  (rready)
    );

    // ---------------- reference model: plain word array, modulo indexing ----------------
    function automatic line_t mk(input logic [63:0] w0, input logic [63:0] w1,
                                 input logic [63:0] w2, input logic [63:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [63:0] init_word(input int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    function automatic logic [1:0] model_write(input int addr, input line_t d,
                                               input logic [31:0] s);
        if (addr >= DEPTH) return 2'b10;
        for (int k = 0; k < LW; k++) begin
            for (int b = 0; b < 8; b++) begin
                if (s[k*8 + b]) mdl[(addr + k) % DEPTH][b*8 +: 8] = d[k*64 + b*8 +: 8];
            end
        end
        return 2'b00;
    endfunction

    task automatic model_read(input int addr, output line_t d, output logic [1:0] r);
        d = '0;
        r = 2'b10;
        if (addr < DEPTH) begin
            r = 2'b00;
            for (int k = 0; k < LW; k++) d[k*64 +: 64] = mdl[(addr + k) % DEPTH];
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------- channel drivers ----------------
    task automatic issue_write(input logic [11:0] a, input line_t d, input logic [31:0] s,
                               input bit do_aw, input bit do_w);
        bit aw_done, w_done, hs_aw, hs_w;
        aw_done = !do_aw;
        w_done  = !do_w;
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = do_aw;
        wvalid  = do_w;
        for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            step();
            if (hs_aw) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (hs_w)  begin w_done  = 1'b1; wvalid  = 1'b0; end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) timeout("write_handshake");
    endtask

    task automatic issue_read(input logic [11:0] a);
        bit done;
        done    = 1'b0;
        araddr  = a;
        arvalid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            done = arready;
            step();
        end
        arvalid = 1'b0;
        if (!done) timeout("read_handshake");
    endtask

    task automatic wait_b(input logic [1:0] exp, input string name);
        bit got;
        got    = 1'b0;
        bready = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            if (bvalid) begin
                got = 1'b1;
                check(name, line_t'(bresp), line_t'(exp));
            end
            step();
        end
        bready = 1'b0;
        if (!got) timeout(name);
    endtask

    task automatic wait_r(input line_t ed, input logic [1:0] er, input string name);
        bit got;
        got    = 1'b0;
        rready = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            if (rvalid) begin
                got = 1'b1;
                check({name, "_rdata"}, rdata, ed);
                check({name, "_rresp"}, line_t'(rresp), line_t'(er));
            end
            step();
        end
        rready = 1'b0;
        if (!got) timeout(name);
    endtask

    task automatic do_write(input logic [11:0] a, input line_t d, input logic [31:0] s,
                            input string name);
        logic [1:0] exp;
        exp = model_write(int'(a), d, s);
        issue_write(a, d, s, 1'b1, 1'b1);
        wait_b(exp, name);
    endtask

    task automatic do_read(input logic [11:0] a, input string name);
        line_t      ed;
        logic [1:0] er;
        model_read(int'(a), ed, er);
        issue_read(a);
        wait_r(ed, er, name);
    endtask

    function automatic line_t rand_line();
        line_t d;
        for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // Watchdog so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- main test ----------------
    initial begin
        vec_t        vt [13];
        line_t       d1, ed;
        logic [1:0]  er;
        logic [63:0] wa, wb, wc, wd, ones;
        int          nrd;

        rst = 1'b1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        repeat (3) step();
        check("rst_awready", line_t'(awready), line_t'(0));
        check("rst_wready", line_t'(wready), line_t'(0));
        check("rst_arready", line_t'(arready), line_t'(0));
        rst = 1'b0;
        #1;
        check("rst_bvalid", line_t'(bvalid), line_t'(0));
        check("rst_rvalid", line_t'(rvalid), line_t'(0));
        check("rst_resps", line_t'({bresp, rresp}), line_t'(0));
        check("rst_rdata", rdata, '0);
        check("rst_readies", line_t'({awready, wready, arready}), line_t'(3'b111));

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i += LW) begin
            do_write(12'(i), mk(init_word(i), init_word(i+1), init_word(i+2), init_word(i+3)),
                     '1, "init_write");
        end

        // Directed table.
        wa = 64'hAAAA_AAAA_AAAA_AAAA; wb = 64'hBBBB_BBBB_BBBB_BBBB;
        wc = 64'hCCCC_CCCC_CCCC_CCCC; wd = 64'hDDDD_DDDD_DDDD_DDDD;
        ones = '1;
        vt[0]  = '{0, 12'h010, mk(0, 1, 2, 3), '1, 2'b00, '0};
        vt[1]  = '{1, 12'h010, '0, '0, 2'b00, mk(0, 1, 2, 3)};
        vt[2]  = '{0, 12'h020, '1, '1, 2'b00, '0};
        vt[3]  = '{0, 12'h020, '0, 32'h0000_00FF, 2'b00, '0};
        vt[4]  = '{1, 12'h020, '0, '0, 2'b00, mk(0, ones, ones, ones)};
        vt[5]  = '{0, 12'd1022, mk(wa, wb, wc, wd), '1, 2'b00, '0};
        vt[6]  = '{1, 12'd1022, '0, '0, 2'b00, mk(wa, wb, wc, wd)};
        vt[7]  = '{0, 12'h400, '1, '1, 2'b10, '0};
        vt[8]  = '{1, 12'h000, '0, '0, 2'b00, mk(wc, wd, init_word(2), init_word(3))};
        vt[9]  = '{1, 12'h400, '0, '0, 2'b10, '0};
        vt[10] = '{0, 12'hFFF, mk(1, 1, 1, 1), '1, 2'b10, '0};
        vt[11] = '{1, 12'hFFF, '0, '0, 2'b10, '0};
        vt[12] = '{1, 12'd1023, '0, '0, 2'b00, mk(wb, wc, wd, init_word(2))};
        for (int i = 0; i < 13; i++) begin
            if (vt[i].rd) begin
                issue_read(vt[i].addr);
                wait_r(vt[i].edata, vt[i].eresp, $sformatf("vec%0d", i));
            end else begin
                er = model_write(int'(vt[i].addr), vt[i].data, vt[i].strb);
                issue_write(vt[i].addr, vt[i].data, vt[i].strb, 1'b1, 1'b1);
                wait_b(vt[i].eresp, $sformatf("vec%0d_bresp", i));
            end
        end

        // Latency: AW first, W two cycles later, B one cycle after the W handshake.
        d1 = mk(0, 1, 2, 3) ^ rand_line();
        er = model_write(12'h010, d1, '1);
        issue_write(12'h010, d1, '1, 1'b1, 1'b0);
        step();
        step();
        issue_write(12'h010, d1, '1, 1'b0, 1'b1);
        check("lat_b_not_early", line_t'(bvalid), line_t'(0));
        step();
        check("lat_bvalid", line_t'(bvalid), line_t'(1));
        wait_b(2'b00, "lat_bresp");
        do_read(12'h010, "lat_read");

        // Random traffic, biased toward the wrap and out-of-range region.
        for (int i = 0; i < 300; i++) begin
            logic [11:0] a;
            a = 12'($urandom_range(0, 1100));
            if ($urandom_range(0, 7) == 0) a = 12'($urandom_range(1018, 1026));
            if ($urandom_range(0, 1) == 0) do_write(a, rand_line(), $urandom, "rand_write");
            else do_read(a, "rand_read");
        end

        // Continuous AW+W and AR to one address right after reset: W,R,W,R...
        pulse_reset();
        d1 = rand_line();
        er = model_write(12'h030, d1, '1);
        awaddr = 12'h030; wdata = d1; wstrb = '1; araddr = 12'h030;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("alt_cycle%0d", i), line_t'({bvalid, rvalid}),
                  line_t'((i == 0) ? 2'b00 : (i % 2 == 1) ? 2'b10 : 2'b01));
            if (rvalid) check("alt_rdata", rdata, d1);
        end
        awvalid = 0; wvalid = 0; arvalid = 0;
        repeat (6) step();

        // B back-pressure stalls writes while reads keep flowing.
        d1 = rand_line();
        er = model_write(12'h040, d1, '1);
        model_read(12'h050, ed, er);
        awaddr = 12'h040; wdata = d1; araddr = 12'h050;
        bready = 0; rready = 1; awvalid = 1; wvalid = 1; arvalid = 1;
        nrd = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rvalid) begin
                nrd++;
                check("stall_rdata", rdata, ed);
            end
        end
        check("stall_bvalid", line_t'(bvalid), line_t'(1));
        check("stall_reads_flow", line_t'(nrd >= 4), line_t'(1));
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1;
        repeat (6) step();
        bready = 0; rready = 0;
        do_read(12'h040, "stall_after_read");

        // Reset while a read response waits and an AW is held alone.
        issue_read(12'h060);
        for (int n = 0; n < 20 && !rvalid; n++) step();
        check("pre_rst_rvalid", line_t'(rvalid), line_t'(1));
        d1 = rand_line();
        issue_write(12'h070, d1, '1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_awready", line_t'(awready), line_t'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_rvalid", line_t'(rvalid), line_t'(0));
        check("post_rst_awready", line_t'(awready), line_t'(1));
        check("post_rst_rdata", rdata, '0);
        issue_write(12'h000, d1, '1, 1'b0, 1'b1);
        repeat (4) step();
        check("dropped_aw_no_write", line_t'(bvalid), line_t'(0));
        er = model_write(12'h080, d1, '1);
        issue_write(12'h080, d1, '1, 1'b1, 1'b0);
        wait_b(2'b00, "late_aw_bresp");
        do_read(12'h070, "rst_untouched");
        do_read(12'h080, "rst_late_write");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
